bb8051_sfr_access_ctrl: RTL and testbench
=========================================

Name: bb8051_sfr_access_ctrl

Overview:
- Sequencer and arbiter in front of the SFR bus of bb8051_sfr_manager.
- Accepts byte and bit access requests from the CPU core, and hardware flag-set requests (timer overflow, interrupt flags) from peripheral logic.
- Grants one requester at a time and turns bit operations into atomic read-modify-write cycles on the byte-wide SFR bus.
- Returns read data and error status to the core.

Parameters:
- HW_PRIORITY, 1: 1 = hardware flag-set requests always win; 0 = round-robin between CPU and hardware.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  CPU request valid
- req_ready  out  1  CPU request accepted this cycle (combinational)
- req_op  in  3  000 byte rd, 001 byte wr, 010 bit rd, 011 bit set, 100 bit clr, 101 bit cpl, 110 bit mov, 111 reserved
- req_addr  in  8  byte address (byte ops) or bit address (bit ops)
- req_wdata  in  8  byte write data
- req_bit  in  1  source bit for bit mov
- rsp_valid  out  1  one-cycle CPU response pulse
- rsp_data  out  8  read data; bit rd returns {7'b0,bit}; 0 for writes
- rsp_err  out  1  qualifies rsp_valid: illegal op or address
- hw_valid  in  1  hardware flag-set request
- hw_bit_addr  in  8  bit address to set
- hw_ready  out  1  hardware request accepted this cycle (combinational)
- sfr_addr  out  8  SFR byte address
- sfr_rd  out  1  read strobe; sfr_rdata sampled in the same cycle
- sfr_wr  out  1  write strobe
- sfr_wdata  out  8  write data
- sfr_rdata  in  8  read data from SFR bus

Behaviour:
- Reset values: state IDLE; all outputs 0. Round-robin pointer favours CPU first.
- States:
  - IDLE: grant, or nothing if no request.
  - RD: sfr_rd=1; capture sfr_rdata.
  - WR: sfr_wr=1.
  - RSP: rsp_valid=1.
  - Back to IDLE after RSP. A hardware op also returns to IDLE after WR, with no RSP state.
- Grant happens only in IDLE. req_ready/hw_ready are 0 in every other state, so at most one is 1 in a cycle.
- Arbitration with both requesters valid:
  - HW_PRIORITY=1: hardware wins.
  - HW_PRIORITY=0: the requester not granted last wins. The pointer updates on every grant.
- Request fields are registered at grant. Inputs may change afterwards.
- Bit address decode: bit_addr[7]=1 required. Byte address = {bit_addr[7:3],3'b000}; index = bit_addr[2:0].
- Byte ops require req_addr[7]=1.
- Illegal cases (address bit7=0, or op 111):
  - IDLE -> RSP directly, no SFR strobes, rsp_err=1, rsp_data=0.
  - For a hardware request: accepted, silently dropped, no strobes.
- Sequences and latency, where grant is cycle T:
  - byte rd: RD T+1, RSP T+2.
  - byte wr: WR T+1 (sfr_wdata=req_wdata), RSP T+2.
  - bit rd: RD T+1, RSP T+2.
  - bit set/clr/cpl/mov: RD T+1, WR T+2 with captured byte and only the indexed bit modified (set 1 / clr 0 / invert / req_bit), RSP T+3.
  - hw set: RD T+1, WR T+2 with indexed bit forced to 1; next grant possible T+3.
- Atomicity: no other SFR strobe between RD and WR of one RMW. A request arriving mid-sequence waits.
- sfr_addr holds the decoded byte address during RD and WR, and is 0 otherwise.
- sfr_wdata is 0 except in WR.
- rsp_valid lasts exactly one cycle. There is no backpressure on the response.
- rst asserted in any state: next cycle IDLE, outputs 0, no pending WR or RSP issued. An aborted RMW leaves the SFR unmodified if rst hits during RD.
- A hardware set of a bit that is already 1 still performs RD+WR (idempotent).

Test Plan:
- Byte write 0x5A to 0xE0, then byte read 0xE0 (bus model returns the stored value) -> sfr_wr at T+1 with addr 0xE0, data 0x5A; read rsp_valid at T+2 with rsp_data 0x5A, rsp_err 0.
- SFR 0xD0 holds 0x81; bit cpl on 0xD7, then bit clr on 0xD0 -> first WR data 0x01, second WR data 0x00. Each has RD/WR in consecutive cycles and rsp_valid at T+3.
- Simultaneous CPU bit set 0x88 and hw set 0x8F, HW_PRIORITY=1 -> hw granted first, CPU granted at T+3. TCON (0x88), starting 0x00, ends 0x81. Repeat with HW_PRIORITY=0 after a prior hw grant -> CPU granted first.
- CPU byte read at 0x30 and op 111 at 0xE0 -> rsp_valid at T+1, rsp_err 1, no sfr_rd/sfr_wr asserted.
- Assert rst during the RD cycle of a bit set on 0xA8 -> no sfr_wr, no rsp_valid. All outputs 0 the next cycle, and a new request is granted immediately after rst deasserts.

Source files
------------

// File: rtl/bb8051_sfr_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : bb8051_sfr_access_ctrl_if
// Brief    : CPU request/response, hardware flag-set and SFR bus signal bundle
// Revision : 1.0
// ============================================================================
interface bb8051_sfr_access_ctrl_if;
   logic       req_valid;
   logic       req_ready;
   logic [2:0] req_op;
   logic [7:0] req_addr;
   logic [7:0] req_wdata;
   logic       req_bit;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       rsp_err;
   logic       hw_valid;
   logic [7:0] hw_bit_addr;
   logic       hw_ready;
   logic [7:0] sfr_addr;
   logic       sfr_rd;
   logic       sfr_wr;
   logic [7:0] sfr_wdata;
   logic [7:0] sfr_rdata;

   // master: requesters and the SFR bus model; slave: the access controller
   modport master (
      output req_valid, req_op, req_addr, req_wdata, req_bit,
      output hw_valid, hw_bit_addr, sfr_rdata,
      input  req_ready, rsp_valid, rsp_data, rsp_err, hw_ready,
      input  sfr_addr, sfr_rd, sfr_wr, sfr_wdata
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata, req_bit,
      input  hw_valid, hw_bit_addr, sfr_rdata,
      output req_ready, rsp_valid, rsp_data, rsp_err, hw_ready,
      output sfr_addr, sfr_rd, sfr_wr, sfr_wdata
   );
endinterface
`default_nettype wire

// File: rtl/bb8051_sfr_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bb8051_sfr_access_ctrl
// Brief    : Arbitrates CPU/hardware SFR accesses; bit ops become atomic RMW
// Revision : 1.0
// ============================================================================
module bb8051_sfr_access_ctrl #(
   parameter int HW_PRIORITY = 1
) (
   input  wire logic               clk,
   input  wire logic               rst,
   bb8051_sfr_access_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2,
      S_RSP  = 2'd3
   } state_t;

   localparam logic [2:0] c_OP_BYTE_RD = 3'b000;
   localparam logic [2:0] c_OP_BYTE_WR = 3'b001;
   localparam logic [2:0] c_OP_BIT_RD  = 3'b010;
   localparam logic [2:0] c_OP_BIT_SET = 3'b011;
   localparam logic [2:0] c_OP_BIT_CLR = 3'b100;
   localparam logic [2:0] c_OP_BIT_CPL = 3'b101;
   localparam logic [2:0] c_OP_BIT_MOV = 3'b110;
   localparam logic [2:0] c_OP_RSVD    = 3'b111;

   state_t     r_state;
   state_t     w_state_nxt;
   logic       r_is_hw;
   logic [2:0] r_op;
   logic [7:0] r_addr;
   logic [2:0] r_idx;
   logic [7:0] r_wdata;
   logic       r_bit;
   logic [7:0] r_rdata;
   logic       r_err;
   logic       r_last_hw;

   logic       w_idle;
   logic       w_hw_win;
   logic       w_cpu_win;
   logic       w_grant_hw;
   logic       w_grant_cpu;
   logic       w_cpu_bitop;
   logic       w_cpu_illegal;
   logic       w_hw_illegal;
   logic       w_mod_bit;
   logic [7:0] w_rmw;

   // Arbitration: r_last_hw marks who was granted last (reset value gives CPU the first turn)
   always_comb begin
      w_idle        = (r_state == S_IDLE) && !rst;
      w_hw_win      = bus.hw_valid && (!bus.req_valid || (HW_PRIORITY != 0) || !r_last_hw);
      w_cpu_win     = bus.req_valid && !w_hw_win;
      w_grant_hw    = w_idle && w_hw_win;
      w_grant_cpu   = w_idle && w_cpu_win;
      w_cpu_bitop   = (bus.req_op != c_OP_BYTE_RD) && (bus.req_op != c_OP_BYTE_WR) &&
                      (bus.req_op != c_OP_RSVD);
      w_cpu_illegal = !bus.req_addr[7] || (bus.req_op == c_OP_RSVD);
      w_hw_illegal  = !bus.hw_bit_addr[7];
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_grant_hw)
               w_state_nxt = w_hw_illegal ? S_IDLE : S_RD;
            else if (w_grant_cpu)
               w_state_nxt = w_cpu_illegal ? S_RSP :
                             ((bus.req_op == c_OP_BYTE_WR) ? S_WR : S_RD);
         end
         S_RD:    w_state_nxt = (r_op >= c_OP_BIT_SET) ? S_WR : S_RSP;
         S_WR:    w_state_nxt = r_is_hw ? S_IDLE : S_RSP;
         S_RSP:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Hardware grants are stored as a bit-set so the RMW datapath is shared
   always_ff @(posedge clk) begin
      if (rst) begin
         r_is_hw   <= 1'b0;
         r_op      <= 3'b000;
         r_addr    <= 8'h00;
         r_idx     <= 3'b000;
         r_wdata   <= 8'h00;
         r_bit     <= 1'b0;
         r_rdata   <= 8'h00;
         r_err     <= 1'b0;
         r_last_hw <= 1'b1;
      end else begin
         if (w_grant_hw) begin
            r_is_hw   <= 1'b1;
            r_op      <= c_OP_BIT_SET;
            r_addr    <= {bus.hw_bit_addr[7:3], 3'b000};
            r_idx     <= bus.hw_bit_addr[2:0];
            r_wdata   <= 8'h00;
            r_bit     <= 1'b0;
            r_err     <= w_hw_illegal;
            r_last_hw <= 1'b1;
         end else if (w_grant_cpu) begin
            r_is_hw   <= 1'b0;
            r_op      <= bus.req_op;
            r_addr    <= w_cpu_bitop ? {bus.req_addr[7:3], 3'b000} : bus.req_addr;
            r_idx     <= bus.req_addr[2:0];
            r_wdata   <= bus.req_wdata;
            r_bit     <= bus.req_bit;
            r_err     <= w_cpu_illegal;
            r_last_hw <= 1'b0;
         end
         if (r_state == S_RD)
            r_rdata <= bus.sfr_rdata;
      end
   end

   always_comb begin
      case (r_op)
         c_OP_BIT_SET: w_mod_bit = 1'b1;
         c_OP_BIT_CLR: w_mod_bit = 1'b0;
         c_OP_BIT_CPL: w_mod_bit = ~r_rdata[r_idx];
         c_OP_BIT_MOV: w_mod_bit = r_bit;
         default:      w_mod_bit = 1'b0;
      endcase
      w_rmw        = r_rdata;
      w_rmw[r_idx] = w_mod_bit;
   end

   assign bus.req_ready = w_grant_cpu;
   assign bus.hw_ready  = w_grant_hw;
   assign bus.sfr_rd    = (r_state == S_RD);
   assign bus.sfr_wr    = (r_state == S_WR);
   assign bus.sfr_addr  = ((r_state == S_RD) || (r_state == S_WR)) ? r_addr : 8'h00;
   assign bus.sfr_wdata = (r_state != S_WR)       ? 8'h00 :
                          (r_op == c_OP_BYTE_WR)  ? r_wdata : w_rmw;
   assign bus.rsp_valid = (r_state == S_RSP);
   assign bus.rsp_err   = (r_state == S_RSP) && r_err;
   assign bus.rsp_data  = ((r_state != S_RSP) || r_err) ? 8'h00 :
                          (r_op == c_OP_BYTE_RD)        ? r_rdata :
                          (r_op == c_OP_BIT_RD)         ? {7'b0, r_rdata[r_idx]} : 8'h00;
endmodule
`default_nettype wire

// File: tb/tb_bb8051_sfr_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bb8051_sfr_access_ctrl
// Brief    : Directed bench: b0/dut0 fixed hardware priority, b1/dut1 round-robin
// Revision : 1.0
// ============================================================================
module tb_bb8051_sfr_access_ctrl;
   logic        clk;
   logic        rst;
   logic        mem_clr;
   logic [7:0]  mem [256];
   logic [31:0] got;
   logic [31:0] exp;
   int          checks;
   int          failures;

   bb8051_sfr_access_ctrl_if b0();
   bb8051_sfr_access_ctrl_if b1();

   bb8051_sfr_access_ctrl #(.HW_PRIORITY(1)) dut0 (.clk(clk), .rst(rst), .bus(b0));
   bb8051_sfr_access_ctrl #(.HW_PRIORITY(0)) dut1 (.clk(clk), .rst(rst), .bus(b1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SFR bus model: combinational read, write on the clock edge
   assign b0.sfr_rdata = mem[b0.sfr_addr];
   assign b1.sfr_rdata = mem[b1.sfr_addr];
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      end else begin
         if (b0.sfr_wr) mem[b0.sfr_addr] <= b0.sfr_wdata;
         if (b1.sfr_wr) mem[b1.sfr_addr] <= b1.sfr_wdata;
      end
   end

   task automatic cpu0(input logic [2:0] op, input logic [7:0] addr,
                       input logic [7:0] wd, input logic bv);
      b0.req_valid = 1'b1; b0.req_op = op; b0.req_addr = addr;
      b0.req_wdata = wd;   b0.req_bit = bv;
   endtask

   task automatic cpu1(input logic [2:0] op, input logic [7:0] addr);
      b1.req_valid = 1'b1; b1.req_op = op; b1.req_addr = addr;
      b1.req_wdata = 8'h00; b1.req_bit = 1'b0;
   endtask

   task automatic test_reset();
      got = {2'b0, b0.rsp_valid, b0.rsp_err, b0.rsp_data, b0.sfr_addr, b0.sfr_rd,
             b0.sfr_wr, b0.sfr_wdata, b0.req_ready, b0.hw_ready};
      checks++; if (got !== 32'h0) begin failures++; $display("FAIL reset_b0 got=%h exp=0", got); end
      got = {2'b0, b1.rsp_valid, b1.rsp_err, b1.rsp_data, b1.sfr_addr, b1.sfr_rd,
             b1.sfr_wr, b1.sfr_wdata, b1.req_ready, b1.hw_ready};
      checks++; if (got !== 32'h0) begin failures++; $display("FAIL reset_b1 got=%h exp=0", got); end
   endtask

   task automatic test_byte_wr_rd();
      @(negedge clk); cpu0(3'b001, 8'hE0, 8'h5A, 1'b0); #1;
      checks++; if (b0.req_ready !== 1'b1) begin failures++; $display("FAIL bwr_ready got=%b exp=1", b0.req_ready); end
      @(negedge clk); b0.req_valid = 1'b0;
      got = {14'b0, b0.sfr_wr, b0.sfr_rd, b0.sfr_addr, b0.sfr_wdata}; exp = {14'b0, 1'b1, 1'b0, 8'hE0, 8'h5A};
      checks++; if (got !== exp) begin failures++; $display("FAIL bwr_strobe got=%h exp=%h", got, exp); end
      @(negedge clk);
      got = {21'b0, b0.rsp_valid, b0.rsp_err, b0.rsp_data, b0.sfr_wr}; exp = {21'b0, 1'b1, 1'b0, 8'h00, 1'b0};
      checks++; if (got !== exp) begin failures++; $display("FAIL bwr_rsp got=%h exp=%h", got, exp); end
      @(negedge clk); cpu0(3'b000, 8'hE0, 8'h00, 1'b0);
      @(negedge clk); b0.req_valid = 1'b0;
      got = {22'b0, b0.sfr_rd, b0.sfr_wr, b0.sfr_addr}; exp = {22'b0, 1'b1, 1'b0, 8'hE0};
      checks++; if (got !== exp) begin failures++; $display("FAIL brd_strobe got=%h exp=%h", got, exp); end
      @(negedge clk);
      got = {22'b0, b0.rsp_valid, b0.rsp_err, b0.rsp_data}; exp = {22'b0, 1'b1, 1'b0, 8'h5A};
      checks++; if (got !== exp) begin failures++; $display("FAIL brd_rsp got=%h exp=%h", got, exp); end
      @(negedge clk);
      checks++; if (b0.rsp_valid !== 1'b0) begin failures++; $display("FAIL rsp_one_cycle got=%b exp=0", b0.rsp_valid); end
   endtask

   task automatic test_bit_rmw();
      // Preload 0xD0 = 0x81 through a byte write
      cpu0(3'b001, 8'hD0, 8'h81, 1'b0);
      @(negedge clk); b0.req_valid = 1'b0;
      @(negedge clk);
      // cpl D7 -> 0x01, clr D0 -> 0x00, mov 1 to D3 -> 0x08
      for (int k = 0; k < 3; k++) begin
         logic [2:0] op;
         logic [7:0] ba;
         logic [7:0] wexp;
         op   = (k == 0) ? 3'b101 : (k == 1) ? 3'b100 : 3'b110;
         ba   = (k == 0) ? 8'hD7  : (k == 1) ? 8'hD0  : 8'hD3;
         wexp = (k == 0) ? 8'h01  : (k == 1) ? 8'h00  : 8'h08;
         @(negedge clk); cpu0(op, ba, 8'h00, 1'b1); #1;
         checks++; if (b0.req_ready !== 1'b1) begin failures++; $display("FAIL rmw%0d_ready got=%b exp=1", k, b0.req_ready); end
         @(negedge clk); b0.req_valid = 1'b0;
         got = {22'b0, b0.sfr_rd, b0.sfr_wr, b0.sfr_addr}; exp = {22'b0, 1'b1, 1'b0, 8'hD0};
         checks++; if (got !== exp) begin failures++; $display("FAIL rmw%0d_rd got=%h exp=%h", k, got, exp); end
         @(negedge clk);
         got = {14'b0, b0.sfr_rd, b0.sfr_wr, b0.sfr_addr, b0.sfr_wdata}; exp = {14'b0, 1'b0, 1'b1, 8'hD0, wexp};
         checks++; if (got !== exp) begin failures++; $display("FAIL rmw%0d_wr got=%h exp=%h", k, got, exp); end
         @(negedge clk);
         got = {22'b0, b0.rsp_valid, b0.rsp_err, b0.rsp_data}; exp = {22'b0, 1'b1, 1'b0, 8'h00};
         checks++; if (got !== exp) begin failures++; $display("FAIL rmw%0d_rsp got=%h exp=%h", k, got, exp); end
      end
      // bit rd E1: 0x5A bit1 = 1
      @(negedge clk); cpu0(3'b010, 8'hE1, 8'h00, 1'b0);
      @(negedge clk); b0.req_valid = 1'b0;
      got = {22'b0, b0.sfr_rd, b0.sfr_wr, b0.sfr_addr}; exp = {22'b0, 1'b1, 1'b0, 8'hE0};
      checks++; if (got !== exp) begin failures++; $display("FAIL bitrd_strobe got=%h exp=%h", got, exp); end
      @(negedge clk);
      got = {22'b0, b0.rsp_valid, b0.rsp_err, b0.rsp_data}; exp = {22'b0, 1'b1, 1'b0, 8'h01};
      checks++; if (got !== exp) begin failures++; $display("FAIL bitrd_rsp got=%h exp=%h", got, exp); end
   endtask

   task automatic test_hw_priority();
      @(negedge clk);
      cpu0(3'b011, 8'h88, 8'h00, 1'b0); b0.hw_valid = 1'b1; b0.hw_bit_addr = 8'h8F; #1;
      got = {30'b0, b0.hw_ready, b0.req_ready}; exp = 32'h2;
      checks++; if (got !== exp) begin failures++; $display("FAIL hwpri_grant got=%h exp=%h", got, exp); end
      @(negedge clk); b0.hw_valid = 1'b0;
      got = {21'b0, b0.sfr_rd, b0.sfr_addr, b0.req_ready, b0.rsp_valid}; exp = {21'b0, 1'b1, 8'h88, 1'b0, 1'b0};
      checks++; if (got !== exp) begin failures++; $display("FAIL hwpri_rd got=%h exp=%h", got, exp); end
      @(negedge clk);
      got = {14'b0, b0.sfr_wr, b0.sfr_addr, b0.sfr_wdata, b0.req_ready}; exp = {14'b0, 1'b1, 8'h88, 8'h80, 1'b0};
      checks++; if (got !== exp) begin failures++; $display("FAIL hwpri_wr got=%h exp=%h", got, exp); end
      @(negedge clk); #1;
      got = {30'b0, b0.req_ready, b0.rsp_valid}; exp = 32'h2;
      checks++; if (got !== exp) begin failures++; $display("FAIL hwpri_cpu_t3 got=%h exp=%h", got, exp); end
      @(negedge clk); b0.req_valid = 1'b0;
      @(negedge clk);
      got = {23'b0, b0.sfr_wr, b0.sfr_wdata}; exp = {23'b0, 1'b1, 8'h81};
      checks++; if (got !== exp) begin failures++; $display("FAIL hwpri_cpu_wr got=%h exp=%h", got, exp); end
      @(negedge clk);
      checks++; if (b0.rsp_valid !== 1'b1) begin failures++; $display("FAIL hwpri_cpu_rsp got=%b exp=1", b0.rsp_valid); end
      checks++; if (mem[8'h88] !== 8'h81) begin failures++; $display("FAIL tcon_final got=%h exp=81", mem[8'h88]); end
   endtask

   task automatic test_round_robin();
      @(negedge clk);
      cpu1(3'b000, 8'hE0); b1.hw_valid = 1'b1; b1.hw_bit_addr = 8'h90; #1;
      got = {30'b0, b1.req_ready, b1.hw_ready}; exp = 32'h2;
      checks++; if (got !== exp) begin failures++; $display("FAIL rr_first_cpu got=%h exp=%h", got, exp); end
      @(negedge clk);
      @(negedge clk);
      got = {23'b0, b1.rsp_valid, b1.rsp_data}; exp = {23'b0, 1'b1, 8'h5A};
      checks++; if (got !== exp) begin failures++; $display("FAIL rr_cpu_rsp got=%h exp=%h", got, exp); end
      @(negedge clk); #1;
      got = {30'b0, b1.req_ready, b1.hw_ready}; exp = 32'h1;
      checks++; if (got !== exp) begin failures++; $display("FAIL rr_then_hw got=%h exp=%h", got, exp); end
      @(negedge clk);
      @(negedge clk);
      got = {15'b0, b1.sfr_wr, b1.sfr_addr, b1.sfr_wdata}; exp = {15'b0, 1'b1, 8'h90, 8'h01};
      checks++; if (got !== exp) begin failures++; $display("FAIL rr_hw_wr got=%h exp=%h", got, exp); end
      @(negedge clk); #1;
      got = {30'b0, b1.req_ready, b1.hw_ready}; exp = 32'h2;
      checks++; if (got !== exp) begin failures++; $display("FAIL rr_after_hw_cpu got=%h exp=%h", got, exp); end
      @(negedge clk); b1.req_valid = 1'b0; b1.hw_valid = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_illegal();
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         if (k == 0) cpu0(3'b000, 8'h30, 8'h00, 1'b0);
         else        cpu0(3'b111, 8'hE0, 8'h00, 1'b0);
         #1;
         checks++; if (b0.req_ready !== 1'b1) begin failures++; $display("FAIL ill%0d_ready got=%b exp=1", k, b0.req_ready); end
         @(negedge clk); b0.req_valid = 1'b0;
         got = {20'b0, b0.rsp_valid, b0.rsp_err, b0.rsp_data, b0.sfr_rd, b0.sfr_wr};
         exp = {20'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
         checks++; if (got !== exp) begin failures++; $display("FAIL ill%0d_rsp got=%h exp=%h", k, got, exp); end
      end
      // Illegal hardware address: accepted, dropped, controller idle next cycle
      @(negedge clk); b0.hw_valid = 1'b1; b0.hw_bit_addr = 8'h10; #1;
      checks++; if (b0.hw_ready !== 1'b1) begin failures++; $display("FAIL hwill_ready got=%b exp=1", b0.hw_ready); end
      @(negedge clk); b0.hw_valid = 1'b0; cpu0(3'b000, 8'hE0, 8'h00, 1'b0); #1;
      got = {29'b0, b0.sfr_rd, b0.sfr_wr, b0.req_ready}; exp = 32'h1;
      checks++; if (got !== exp) begin failures++; $display("FAIL hwill_drop got=%h exp=%h", got, exp); end
      @(negedge clk); b0.req_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_abort();
      @(negedge clk); cpu0(3'b011, 8'hA8, 8'h00, 1'b0);
      @(negedge clk); b0.req_valid = 1'b0;
      got = {23'b0, b0.sfr_rd, b0.sfr_addr}; exp = {23'b0, 1'b1, 8'hA8};
      checks++; if (got !== exp) begin failures++; $display("FAIL abort_rd got=%h exp=%h", got, exp); end
      rst = 1'b1;
      @(negedge clk);
      got = {2'b0, b0.rsp_valid, b0.rsp_err, b0.rsp_data, b0.sfr_addr, b0.sfr_rd,
             b0.sfr_wr, b0.sfr_wdata, b0.req_ready, b0.hw_ready};
      checks++; if (got !== 32'h0) begin failures++; $display("FAIL abort_outputs got=%h exp=0", got); end
      rst = 1'b0; cpu0(3'b000, 8'hE0, 8'h00, 1'b0); #1;
      checks++; if (b0.req_ready !== 1'b1) begin failures++; $display("FAIL abort_regrant got=%b exp=1", b0.req_ready); end
      checks++; if (mem[8'hA8] !== 8'h00) begin failures++; $display("FAIL abort_sfr got=%h exp=00", mem[8'hA8]); end
      @(negedge clk); b0.req_valid = 1'b0;
      @(negedge clk);
      got = {22'b0, b0.rsp_valid, b0.rsp_err, b0.rsp_data}; exp = {22'b0, 1'b1, 1'b0, 8'h5A};
      checks++; if (got !== exp) begin failures++; $display("FAIL abort_after_rsp got=%h exp=%h", got, exp); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      checks = 0; failures = 0;
      rst = 1'b1; mem_clr = 1'b1;
      b0.req_valid = 1'b0; b0.req_op = 3'b000; b0.req_addr = 8'h00; b0.req_wdata = 8'h00;
      b0.req_bit = 1'b0; b0.hw_valid = 1'b0; b0.hw_bit_addr = 8'h00;
      b1.req_valid = 1'b0; b1.req_op = 3'b000; b1.req_addr = 8'h00; b1.req_wdata = 8'h00;
      b1.req_bit = 1'b0; b1.hw_valid = 1'b0; b1.hw_bit_addr = 8'h00;
      repeat (3) @(negedge clk);
      test_reset();
      rst = 1'b0; mem_clr = 1'b0;
      test_byte_wr_rd();
      test_bit_rmw();
      test_hw_priority();
      test_round_robin();
      test_illegal();
      test_reset_abort();
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
